// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor that adds CHUNK bits per clock, with carry/overflow/zero flags.
// Optional result clamping on signed overflow is enabled by defining SATURATE_EN.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_add_sub: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_fin;
  logic             ov_raw;

`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);

  // Clamp toward the signed extreme that matches A's sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                input logic ov, input logic a_msb);
    if (ov) return a_msb ? MIN_NEG : ~MIN_NEG;
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    z_d     = z_q;

    chunk_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
              + (CHUNK+1)'(carry_q);
    res_raw = res_q;
    res_raw[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    // b_q already holds the inverted operand for subtraction, so one rule covers both.
    ov_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_raw[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SATURATE_EN
    res_fin = saturate(res_raw, ov_raw, a_q[WIDTH-1]);
`else
    res_fin = res_raw;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d   = res_raw;
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          res_d   = res_fin;
          cy_d    = chunk_sum[CHUNK];
          ov_d    = ov_raw;
          z_d     = (res_fin == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cy_q;
  assign overflow  = ov_q;
  assign zero      = z_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Scoreboard bench for chunked_add_sub: 16/4 instance for the main cases, 4/4 for legacy width.
module tb_chunked_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, carry_out, overflow, zero;
  logic [15:0] result;

  logic        in_valid4 = 1'b0, sub4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, carry_out4, overflow4, zero4;
  logic [3:0]  result4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        cy;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  chunked_add_sub #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .carry_out(carry_out4), .overflow(overflow4), .zero(zero4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] full;
    bb   = ts ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bb} + {16'd0, ts};
    e.cy  = full[16];
    e.ov  = (ta[15] == bb[15]) && (full[15] != ta[15]);
    e.res = full[15:0];
`ifdef SATURATE_EN
    if (e.ov) e.res = ta[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.z = (e.res == 16'h0000);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", {16'd0, result}, {16'd0, mon_e.res});
        check("carry_out", {31'd0, carry_out}, {31'd0, mon_e.cy});
        check("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
        check("zero", {31'd0, zero}, {31'd0, mon_e.z});
      end
    end
  end

  task automatic drive_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                          input int hold);
    int          n;
    logic [15:0] saved;
    logic [2:0]  sflags;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; sub = ts;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_timeout", {31'd0, (n < 50)}, 32'd1);
    sb_q.push_back(model(ta, tb_, ts));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("latency", n, 32'd4);
    saved  = result;
    sflags = {carry_out, overflow, zero};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(negedge clk);
      check("hold_result", {16'd0, result}, {16'd0, saved});
      check("hold_flags", {29'd0, carry_out, overflow, zero}, {29'd0, sflags});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    drive_op(16'h0004, 16'h0002, 1'b0, 0);
    drive_op(16'hFFFF, 16'h0001, 1'b0, 0);
    drive_op(16'h7FFF, 16'h0001, 1'b0, 0);
    drive_op(16'h0002, 16'h0004, 1'b1, 0);
    drive_op(16'h0006, 16'h0006, 1'b1, 0);
    drive_op(16'h8000, 16'h0001, 1'b1, 0);
    drive_op(16'h8000, 16'h8000, 1'b0, 0);
    drive_op(16'h1234, 16'h0FCC, 1'b0, 5);
    for (int i = 0; i < 8; i++) begin
      drive_op(16'($urandom), 16'($urandom), 1'($urandom), i % 3);
    end

    // Reset during the second BUSY cycle must abort with no output.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0123; b = 16'h0456; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_output", {31'd0, out_valid}, 32'd0);
    end

    // Legacy 4-bit width: a single BUSY cycle.
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'd6; b4 = 4'd10; sub4 = 1'b0;
    check("w4_in_ready", {31'd0, in_ready4}, 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
    check("w4_latency", n, 32'd1);
    check("w4_result", {28'd0, result4}, 32'd0);
    check("w4_carry", {31'd0, carry_out4}, 32'd1);
    check("w4_overflow", {31'd0, overflow4}, 32'd0);
    check("w4_zero", {31'd0, zero4}, 32'd1);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("w4_post_out_valid", {31'd0, out_valid4}, 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
